// File: rtl/cache_port_arbiter_pkg.sv
// Shared encodings for the data-cache port arbiter: FSM states, grant and
// store-size codes, and the two-way arbitration rule.
package cache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        CHECK     = 2'd2,
        MISS_WAIT = 2'd3
    } arb_state_e;

    localparam logic GNT_LD    = 1'b0;
    localparam logic GNT_ST    = 1'b1;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    // Urgency overrides fairness; with both pending, the side not served last wins.
    function automatic logic arb_pick(input logic ld_valid, input logic st_valid,
                                      input logic st_urgent, input logic last_grant);
        logic pick;
        if (st_urgent && st_valid) begin
            pick = GNT_ST;
        end else if (ld_valid && st_valid) begin
            pick = ~last_grant;
        end else if (st_valid) begin
            pick = GNT_ST;
        end else begin
            pick = GNT_LD;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Bundle of the load/store request ports, the cache port and the responses
// seen by the cache port arbiter (slave) and its environment (master).
interface cache_port_arbiter_if #(
    parameter int ROB_TAG_W = 6,
    parameter int CNT_W     = 16
);
    logic                 ld_req_valid;
    logic                 ld_req_ready;
    logic [31:0]          ld_req_pc;
    logic [31:0]          ld_req_addr;
    logic [ROB_TAG_W-1:0] ld_req_tag;

    logic                 st_req_valid;
    logic                 st_req_ready;
    logic [31:0]          st_req_pc;
    logic [31:0]          st_req_addr;
    logic [31:0]          st_req_data;
    logic                 st_req_size;
    logic                 st_urgent;

    logic [31:0]          PC_in;
    logic [31:0]          address_in;
    logic [31:0]          data_sw;
    logic                 memRead;
    logic                 memWrite;
    logic                 storeSize;
    logic                 fromLSQ;
    logic [31:0]          lw_data;
    logic                 cacheMiss;

    logic                 ld_resp_valid;
    logic [31:0]          ld_resp_data;
    logic [ROB_TAG_W-1:0] ld_resp_tag;
    logic                 st_done;
    logic                 busy;
    logic [CNT_W-1:0]     miss_count;

    modport master (
        output ld_req_valid, ld_req_pc, ld_req_addr, ld_req_tag,
        output st_req_valid, st_req_pc, st_req_addr, st_req_data, st_req_size, st_urgent,
        output lw_data, cacheMiss,
        input  ld_req_ready, st_req_ready,
        input  PC_in, address_in, data_sw, memRead, memWrite, storeSize, fromLSQ,
        input  ld_resp_valid, ld_resp_data, ld_resp_tag, st_done, busy, miss_count
    );

    modport slave (
        input  ld_req_valid, ld_req_pc, ld_req_addr, ld_req_tag,
        input  st_req_valid, st_req_pc, st_req_addr, st_req_data, st_req_size, st_urgent,
        input  lw_data, cacheMiss,
        output ld_req_ready, st_req_ready,
        output PC_in, address_in, data_sw, memRead, memWrite, storeSize, fromLSQ,
        output ld_resp_valid, ld_resp_data, ld_resp_tag, st_done, busy, miss_count
    );

endinterface

// File: rtl/cache_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with store-urgency override; the only state is
// the record of which side was granted last.
module cache_port_arbiter_rr_arbiter2
    import cache_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ld,
    input  logic req_st,
    input  logic urgent,
    input  logic accept,
    output logic grant_valid,
    output logic grant
);

    logic last_grant_r;

    // Current-cycle grant decision.
    always_comb begin
        grant_valid = req_ld | req_st;
        grant       = arb_pick(req_ld, req_st, urgent, last_grant_r);
    end

    // Remember the winner of each accepted request for the next tie-break.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= GNT_LD;
        end else if (accept) begin
            last_grant_r <= grant;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single data-cache port between the LSQ load port and the store
// commit port, replaying missed requests after a fixed penalty.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int ROB_TAG_W    = 6,
    parameter int MISS_PENALTY = 4,
    parameter int CNT_W        = 16
) (
    input logic                 clk,
    input logic                 rst,
    cache_port_arbiter_if.slave bus
);

    localparam int               WAIT_W    = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MISS_PENALTY - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    arb_state_e           state_r;
    arb_state_e           state_s;
    logic                 grant_r;
    logic [31:0]          pc_r;
    logic [31:0]          addr_r;
    logic [31:0]          data_r;
    logic                 size_r;
    logic [ROB_TAG_W-1:0] tag_r;
    logic [WAIT_W-1:0]    wait_r;
    logic [CNT_W-1:0]     miss_count_r;

    logic                 gnt_valid_s;
    logic                 gnt_s;
    logic                 accept_s;
    logic                 hit_s;
    logic                 miss_s;

    cache_port_arbiter_rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_ld      (bus.ld_req_valid),
        .req_st      (bus.st_req_valid),
        .urgent      (bus.st_urgent),
        .accept      (accept_s),
        .grant_valid (gnt_valid_s),
        .grant       (gnt_s)
    );

    // Next-state logic; an accept is only possible from IDLE outside reset.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s && !rst) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                state_s = CHECK;
            end
            CHECK: begin
                if (bus.cacheMiss) begin
                    state_s = MISS_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            MISS_WAIT: begin
                // CHECK itself counts as one penalty cycle, so leave one count early.
                if (wait_r <= WAIT_ONE) begin
                    state_s = ISSUE;
                end else begin
                    state_s = MISS_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the winning request; loads carry zero data and word size to the cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r <= GNT_LD;
            pc_r    <= 32'd0;
            addr_r  <= 32'd0;
            data_r  <= 32'd0;
            size_r  <= SIZE_WORD;
            tag_r   <= {ROB_TAG_W{1'b0}};
        end else if (accept_s && (gnt_s == GNT_LD)) begin
            grant_r <= GNT_LD;
            pc_r    <= bus.ld_req_pc;
            addr_r  <= bus.ld_req_addr;
            data_r  <= 32'd0;
            size_r  <= SIZE_WORD;
            tag_r   <= bus.ld_req_tag;
        end else if (accept_s) begin
            grant_r <= GNT_ST;
            pc_r    <= bus.st_req_pc;
            addr_r  <= bus.st_req_addr;
            data_r  <= bus.st_req_data;
            size_r  <= bus.st_req_size;
            tag_r   <= tag_r;
        end else begin
            grant_r <= grant_r;
            pc_r    <= pc_r;
            addr_r  <= addr_r;
            data_r  <= data_r;
            size_r  <= size_r;
            tag_r   <= tag_r;
        end
    end

    assign miss_s = (state_r == CHECK) && bus.cacheMiss;

    // Replay wait counter, loaded on a miss and counted down in MISS_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_r <= WAIT_ZERO;
        end else if (miss_s) begin
            wait_r <= WAIT_LOAD;
        end else if ((state_r == MISS_WAIT) && (wait_r != WAIT_ZERO)) begin
            wait_r <= wait_r - WAIT_ONE;
        end else begin
            wait_r <= wait_r;
        end
    end

    // Saturating miss performance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count_r <= {CNT_W{1'b0}};
        end else if (miss_s && (miss_count_r != CNT_MAX)) begin
            miss_count_r <= miss_count_r + CNT_ONE;
        end else begin
            miss_count_r <= miss_count_r;
        end
    end

    // Output decode from the latched request and the current state.
    always_comb begin
        hit_s            = (state_r == CHECK) && !bus.cacheMiss;
        bus.ld_req_ready = accept_s && (gnt_s == GNT_LD);
        bus.st_req_ready = accept_s && (gnt_s == GNT_ST);
        bus.memRead      = (state_r == ISSUE) && (grant_r == GNT_LD);
        bus.memWrite     = (state_r == ISSUE) && (grant_r == GNT_ST);
        bus.fromLSQ      = (state_r == ISSUE) && (grant_r == GNT_LD);
        bus.PC_in        = pc_r;
        bus.address_in   = addr_r;
        bus.data_sw      = data_r;
        bus.storeSize    = size_r;
        bus.st_done      = hit_s && (grant_r == GNT_ST);
        bus.busy         = (state_r != IDLE);
        bus.miss_count   = miss_count_r;
        if (hit_s && (grant_r == GNT_LD)) begin
            bus.ld_resp_valid = 1'b1;
            bus.ld_resp_data  = bus.lw_data;
            bus.ld_resp_tag   = tag_r;
        end else begin
            bus.ld_resp_valid = 1'b0;
            bus.ld_resp_data  = 32'd0;
            bus.ld_resp_tag   = {ROB_TAG_W{1'b0}};
        end
    end

endmodule
